// File: rtl/piradip_sample_buffer_capture_ctrl.sv
// Capture sequencer for the sample buffer's stream-side controls: pre/post-trigger
// ring capture or linear one-shot fill, all in the stream clock domain.
module piradip_sample_buffer_capture_ctrl #(
    parameter int OFFSET_WIDTH = 12
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [OFFSET_WIDTH-1:0] cfg_start_offset,
    input  logic [OFFSET_WIDTH-1:0] cfg_end_offset,
    input  logic [OFFSET_WIDTH-1:0] cfg_pretrigger,
    input  logic [OFFSET_WIDTH-1:0] cfg_posttrigger,
    input  logic                    cfg_one_shot,
    input  logic                    cmd_arm,
    input  logic                    cmd_abort,
    input  logic                    trigger,
    input  logic                    beat,
    input  logic [OFFSET_WIDTH-1:0] wr_addr,
    output logic                    stream_update,
    output logic                    stream_active,
    output logic                    stream_one_shot,
    output logic [OFFSET_WIDTH-1:0] stream_start_offset,
    output logic [OFFSET_WIDTH-1:0] stream_end_offset,
    output logic                    busy,
    output logic                    done,
    output logic                    arm_err,
    output logic [OFFSET_WIDTH-1:0] trig_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_WAIT_TRIG,
        S_POSTTRIG,
        S_FILL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                    trig_q;
    logic                    trig_edge;
    logic [OFFSET_WIDTH-1:0] pre_q, pre_d;
    logic [OFFSET_WIDTH-1:0] post_q, post_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic [OFFSET_WIDTH:0]   cnt_inc;
    logic [OFFSET_WIDTH-1:0] span;
    logic [OFFSET_WIDTH-1:0] pre_clamped;
    logic [OFFSET_WIDTH-1:0] start_d, end_d, trig_addr_d;
    logic                    one_shot_d, update_d, active_d, arm_err_d;
    logic                    busy_d, done_d;

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        post_d      = post_q;
        cnt_d       = cnt_q;
        start_d     = stream_start_offset;
        end_d       = stream_end_offset;
        one_shot_d  = stream_one_shot;
        trig_addr_d = trig_addr;
        active_d    = stream_active;
        update_d    = 1'b0;
        arm_err_d   = 1'b0;

        trig_edge   = trigger & ~trig_q;
        cnt_inc     = {1'b0, cnt_q} + (OFFSET_WIDTH+1)'(1);
        span        = cfg_end_offset - cfg_start_offset;
        pre_clamped = (cfg_pretrigger > span) ? span : cfg_pretrigger;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Abort outranks arm even though abort alone does nothing here.
                if (cmd_arm && !cmd_abort) begin
                    if (cfg_end_offset < cfg_start_offset) begin
                        arm_err_d = 1'b1;
                    end else begin
                        start_d     = cfg_start_offset;
                        end_d       = cfg_end_offset;
                        one_shot_d  = cfg_one_shot;
                        post_d      = cfg_posttrigger;
                        pre_d       = pre_clamped;
                        cnt_d       = '0;
                        trig_addr_d = '0;
                        update_d    = 1'b1;
                        active_d    = 1'b1;
                        state_d     = cfg_one_shot ? S_FILL : S_PRETRIG;
                    end
                end
            end
            S_PRETRIG: begin
                if (cmd_abort) begin
                    update_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == pre_q) begin
                    state_d = S_WAIT_TRIG;
                end else if (beat) begin
                    if (cnt_inc == {1'b0, pre_q}) begin
                        state_d = S_WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_inc[OFFSET_WIDTH-1:0];
                    end
                end
            end
            S_WAIT_TRIG: begin
                if (cmd_abort) begin
                    update_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (trig_edge) begin
                    trig_addr_d = wr_addr;
                    cnt_d       = '0;
                    state_d     = S_POSTTRIG;
                end
            end
            S_POSTTRIG: begin
                if (cmd_abort) begin
                    update_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == post_q) begin
                    update_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_DONE;
                end else if (beat) begin
                    if (cnt_inc == {1'b0, post_q}) begin
                        update_d = 1'b1;
                        active_d = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_inc[OFFSET_WIDTH-1:0];
                    end
                end
            end
            S_FILL: begin
                if (cmd_abort) begin
                    update_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (beat && (wr_addr == stream_end_offset)) begin
                    update_d = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q             <= S_IDLE;
            trig_q              <= 1'b0;
            pre_q               <= '0;
            post_q              <= '0;
            cnt_q               <= '0;
            stream_update       <= 1'b0;
            stream_active       <= 1'b0;
            stream_one_shot     <= 1'b0;
            stream_start_offset <= '0;
            stream_end_offset   <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            arm_err             <= 1'b0;
            trig_addr           <= '0;
        end else begin
            state_q             <= state_d;
            trig_q              <= trigger;
            pre_q               <= pre_d;
            post_q              <= post_d;
            cnt_q               <= cnt_d;
            stream_update       <= update_d;
            stream_active       <= active_d;
            stream_one_shot     <= one_shot_d;
            stream_start_offset <= start_d;
            stream_end_offset   <= end_d;
            busy                <= busy_d;
            done                <= done_d;
            arm_err             <= arm_err_d;
            trig_addr           <= trig_addr_d;
        end
    end

endmodule

// File: tb/tb_piradip_sample_buffer_capture_ctrl.sv
// Directed bench for the capture sequencer; stream_update events are checked
// against a queue of expected active values filled as stimulus is driven.
module tb_piradip_sample_buffer_capture_ctrl;

    localparam int W = 12;

    logic         aclk;
    logic         aresetn;
    logic [W-1:0] cfg_start_offset, cfg_end_offset, cfg_pretrigger, cfg_posttrigger;
    logic         cfg_one_shot, cmd_arm, cmd_abort, trigger, beat;
    logic [W-1:0] wr_addr;
    logic         stream_update, stream_active, stream_one_shot;
    logic [W-1:0] stream_start_offset, stream_end_offset, trig_addr;
    logic         busy, done, arm_err;

    piradip_sample_buffer_capture_ctrl #(.OFFSET_WIDTH(W)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cfg_start_offset   (cfg_start_offset),
        .cfg_end_offset     (cfg_end_offset),
        .cfg_pretrigger     (cfg_pretrigger),
        .cfg_posttrigger    (cfg_posttrigger),
        .cfg_one_shot       (cfg_one_shot),
        .cmd_arm            (cmd_arm),
        .cmd_abort          (cmd_abort),
        .trigger            (trigger),
        .beat               (beat),
        .wr_addr            (wr_addr),
        .stream_update      (stream_update),
        .stream_active      (stream_active),
        .stream_one_shot    (stream_one_shot),
        .stream_start_offset(stream_start_offset),
        .stream_end_offset  (stream_end_offset),
        .busy               (busy),
        .done               (done),
        .arm_err            (arm_err),
        .trig_addr          (trig_addr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int           vectors;
    int           miscompares;
    int           upd_seen;
    bit           exp_q[$];
    logic [W-1:0] rs, re, addr, exp_trig;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and retire any stream_update against the queue.
    task automatic cyc(input logic b, input logic trg);
        bit e;
        beat    = b;
        trigger = trg;
        wr_addr = addr;
        @(posedge aclk);
        #1;
        if (b) addr = (addr == re) ? rs : addr + 1'b1;
        if (stream_update === 1'b1) begin
            upd_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_update", 64'(stream_update), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("update_active", 64'(stream_active), 64'(e));
            end
        end
    endtask

    task automatic setup(input logic [W-1:0] s, input logic [W-1:0] en, input logic [W-1:0] pre,
                         input logic [W-1:0] post, input logic os);
        cfg_start_offset = s;
        cfg_end_offset   = en;
        cfg_pretrigger   = pre;
        cfg_posttrigger  = post;
        cfg_one_shot     = os;
        rs   = s;
        re   = en;
        addr = s;
    endtask

    task automatic arm();
        exp_q.push_back(1'b1);
        cmd_arm = 1'b1;
        cyc(1'b0, 1'b0);
        cmd_arm = 1'b0;
        chk("arm_update", 64'(stream_update), 64'd1);
        chk("arm_busy", 64'({busy, done}), 64'b10);
    endtask

    initial begin
        vectors = 0; miscompares = 0; upd_seen = 0;
        aresetn = 1'b0; cmd_arm = 1'b0; cmd_abort = 1'b0; trigger = 1'b0; beat = 1'b0;
        wr_addr = '0;
        setup(12'd0, 12'd15, 12'd4, 12'd3, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("reset_outputs", {stream_update, stream_active, stream_one_shot, busy, done, arm_err,
                              trig_addr, stream_start_offset, stream_end_offset}, 64'd0);
        aresetn = 1'b1;
        cyc(1'b0, 1'b0);

        // Ring capture: pre=4, post=3, trigger on 7th WAIT_TRIG beat.
        upd_seen = 0;
        arm();
        for (int unsigned i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        for (int unsigned i = 0; i < 6; i++) cyc(1'b1, 1'b0);
        exp_trig = addr;
        cyc(1'b1, 1'b1);
        chk("ring_trig_addr", 64'(trig_addr), 64'(exp_trig));
        chk("ring_trig_addr_val", 64'(trig_addr), 64'd10);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("ring_no_early_stop", 64'({stream_update, done}), 64'd0);
        exp_q.push_back(1'b0);
        cyc(1'b1, 1'b1);
        chk("ring_stop_update", 64'(stream_update), 64'd1);
        chk("ring_done", 64'({busy, done}), 64'b01);
        chk("ring_two_updates", 64'(upd_seen), 64'd2);
        cyc(1'b0, 1'b0);
        chk("ring_active_hold", 64'({stream_update, stream_active}), 64'd0);

        // Pretrigger clamp (100 -> 15); PRETRIG edges ignored, incl. the transition cycle.
        setup(12'd16, 12'd31, 12'd100, 12'd2, 1'b0);
        arm();
        for (int unsigned k = 1; k <= 15; k++) cyc(1'b1, (k == 5) || (k == 15));
        chk("clamp_pretrig_edge_ignored", 64'(trig_addr), 64'd0);
        cyc(1'b1, 1'b0);
        chk("clamp_still_busy", 64'({busy, done}), 64'b10);
        exp_trig = addr;
        cyc(1'b1, 1'b1);
        chk("clamp_wait_edge", 64'(trig_addr), 64'(exp_trig));
        cyc(1'b1, 1'b1);
        exp_q.push_back(1'b0);
        cyc(1'b1, 1'b1);
        chk("clamp_stop", 64'({stream_update, done}), 64'b11);
        cyc(1'b0, 1'b0);

        // One-shot fill 4..9 with gaps and a toggling trigger.
        setup(12'd4, 12'd9, 12'd0, 12'd0, 1'b1);
        arm();
        chk("fill_latched", {stream_one_shot, stream_start_offset, stream_end_offset, trig_addr},
            {1'b1, 12'd4, 12'd9, 12'd0});
        for (int unsigned i = 0; i < 40 && !done; i++) begin
            logic b;
            logic hit;
            b   = (i % 3) != 2;
            hit = b && (addr == 12'd9);
            if (hit) exp_q.push_back(1'b0);
            cyc(b, i[0]);
            chk("fill_update_timing", 64'(stream_update), 64'(hit));
        end
        chk("fill_done", 64'({busy, done}), 64'b01);
        chk("fill_trig_addr", 64'(trig_addr), 64'd0);
        cyc(1'b0, 1'b0);

        // Abort in POSTTRIG.
        setup(12'd0, 12'd15, 12'd2, 12'd5, 1'b0);
        arm();
        chk("arm_clears_done", 64'(done), 64'd0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        exp_q.push_back(1'b0);
        cmd_abort = 1'b1;
        cyc(1'b1, 1'b1);
        cmd_abort = 1'b0;
        chk("abort_update", 64'({stream_update, stream_active}), 64'b10);
        chk("abort_idle", 64'({busy, done}), 64'b00);
        cyc(1'b0, 1'b0);

        // Arm with abort in IDLE: nothing happens.
        upd_seen = 0;
        cmd_arm = 1'b1; cmd_abort = 1'b1;
        cyc(1'b0, 1'b0);
        cmd_arm = 1'b0; cmd_abort = 1'b0;
        cyc(1'b0, 1'b0);
        chk("arm_abort_idle", 64'({busy, done, upd_seen[0]}), 64'd0);

        // Zero pre/post counts.
        setup(12'd5, 12'd12, 12'd0, 12'd0, 1'b0);
        arm();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("zero_trig_at_arm2", 64'({trig_addr, stream_update, busy}), {12'd5, 1'b0, 1'b1});
        exp_q.push_back(1'b0);
        cyc(1'b0, 1'b1);
        chk("zero_done_at_trig2", 64'({stream_update, done}), 64'b11);

        // Rejected arm from DONE.
        upd_seen = 0;
        cfg_start_offset = 12'd5; cfg_end_offset = 12'd3;
        cmd_arm = 1'b1;
        cyc(1'b0, 1'b0);
        cmd_arm = 1'b0;
        chk("reject_arm_err", 64'({arm_err, done, stream_update}), 64'b110);
        chk("reject_no_latch", 64'({stream_start_offset, stream_end_offset}), {12'd5, 12'd12});
        cyc(1'b0, 1'b0);
        chk("reject_err_pulse", 64'({arm_err, upd_seen[0]}), 64'd0);

        // Reset while in WAIT_TRIG, then re-arm.
        setup(12'd0, 12'd15, 12'd1, 12'd1, 1'b0);
        arm();
        cyc(1'b1, 1'b0);
        aresetn = 1'b0;
        cyc(1'b0, 1'b0);
        chk("midreset_outputs", {stream_update, stream_active, stream_one_shot, busy, done, arm_err,
                                 trig_addr, stream_start_offset, stream_end_offset}, 64'd0);
        aresetn = 1'b1;
        setup(12'd2, 12'd7, 12'd1, 12'd1, 1'b0);
        arm();
        chk("rearm_latched", 64'({stream_start_offset, stream_end_offset}), {12'd2, 12'd7});
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        exp_trig = addr;
        cyc(1'b0, 1'b1);
        chk("rearm_trig", 64'(trig_addr), 64'(exp_trig));
        exp_q.push_back(1'b0);
        cyc(1'b1, 1'b1);
        chk("rearm_done", 64'({stream_update, done}), 64'b11);
        cyc(1'b0, 1'b0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
